// File: rtl/stall_ctrl.sv
// stall_ctrl: hazard/stall controller for the five-stage pipeline.
// Detects RAW hazards that forwarding cannot cover, tracks the mult/div
// busy window, and drives PC/IF-ID enables and the ID/EX bubble clear.
module stall_ctrl #(
    parameter int unsigned MULT_LAT = 5,
    parameter int unsigned DIV_LAT  = 10,
    parameter int unsigned CNT_W    = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  rsD,
    input  logic [4:0]  rtD,
    input  logic [1:0]  TuseRsD,
    input  logic [1:0]  TuseRtD,
    input  logic [4:0]  A3E,
    input  logic [1:0]  TnewE,
    input  logic [4:0]  A3M,
    input  logic [1:0]  TnewM,
    input  logic        mdUseD,
    input  logic        mdStartE,
    input  logic        mdIsDivE,
    output logic        PC_en,
    output logic        IFID_en,
    output logic        IDEX_clr,
    output logic        md_busy,
    output logic [31:0] stall_cycles
);

    localparam int unsigned SC_W = 32;

    // Busy-window state is implied by the counter value
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [SC_W-1:0]  stall_cycles_q;
    logic [SC_W-1:0]  stall_cycles_d;
    logic [0:0]       state;
    logic             rs_haz;
    logic             rt_haz;
    logic             md_haz;
    logic             stall;

    assign state        = (cnt_q != '0) ? ST_BUSY : ST_IDLE;
    assign md_busy      = (state == ST_BUSY);
    assign stall_cycles = stall_cycles_q;

    // Hazard detection; $0 never matches and Tuse==3 means operand unused
    always_comb begin
        rs_haz = (TuseRsD != 2'd3) && (rsD != 5'd0) &&
                 (((rsD == A3E) && (TnewE > TuseRsD)) ||
                  ((rsD == A3M) && (TnewM > TuseRsD)));
        rt_haz = (TuseRtD != 2'd3) && (rtD != 5'd0) &&
                 (((rtD == A3E) && (TnewE > TuseRtD)) ||
                  ((rtD == A3M) && (TnewM > TuseRtD)));
        md_haz = mdUseD && (md_busy || mdStartE);
        // Reset forces the pipeline to run freely
        stall    = reset && (rs_haz || rt_haz || md_haz);
        PC_en    = ~stall;
        IFID_en  = ~stall;
        IDEX_clr = stall;
    end

    // Next-state: load on issue when idle, count down when busy
    always_comb begin
        cnt_d          = cnt_q;
        stall_cycles_d = stall_cycles_q;
        case (state)
            ST_IDLE: begin
                if (mdStartE) begin
                    cnt_d = mdIsDivE ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);
                end
            end
            ST_BUSY: begin
                // A start while busy is illegal and deliberately ignored
                cnt_d = cnt_q - CNT_W'(1);
            end
            default: cnt_d = '0;
        endcase
        if (stall && (stall_cycles_q != {SC_W{1'b1}})) begin
            stall_cycles_d = stall_cycles_q + SC_W'(1);
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q          <= '0;
            stall_cycles_q <= '0;
        end else begin
            cnt_q          <= cnt_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

endmodule

// File: doc/stall_ctrl.md
# stall_ctrl

Hazard and stall controller for the five-stage pipeline. It generates the enables for the PC register and the IF/ID pipeline register, and the clear for the ID/EX register. It detects RAW hazards that forwarding cannot cover (Tuse/Tnew comparison against E and M), and it tracks the busy window of the multi-cycle mult/div unit. It sits beside the decode stage and drives the pipeline registers directly.

## Interface
Parameters:
- MULT_LAT, 5, busy cycles after a mult/multu issues from E
- DIV_LAT, 10, busy cycles after a div/divu issues from E
- CNT_W, 4, width of the busy counter; must hold max(MULT_LAT, DIV_LAT)

Ports:
- clk  in  1  clock; all state updates on posedge
- reset  in  1  synchronous, active-low; reset==0 at a posedge clears all state
- rsD  in  5  D-stage rs register number
- rtD  in  5  D-stage rt register number
- TuseRsD  in  2  cycles until D instr needs rs (0..2); 3 = rs not used
- TuseRtD  in  2  same for rt
- A3E  in  5  E-stage destination register
- TnewE  in  2  cycles until E result is available
- A3M  in  5  M-stage destination register
- TnewM  in  2  cycles until M result is available
- mdUseD  in  1  D instr is mult/multu/div/divu/mfhi/mflo/mthi/mtlo
- mdStartE  in  1  E instr starts the mult/div unit this cycle
- mdIsDivE  in  1  qualifies mdStartE: 1 = div, 0 = mult
- PC_en  out  1  PC register write enable
- IFID_en  out  1  IF/ID register write enable
- IDEX_clr  out  1  synchronous clear (bubble insert) for ID/EX
- md_busy  out  1  mult/div unit busy
- stall_cycles  out  32  saturating count of stalled cycles

## Operation
- rs hazard: TuseRsD!=3 && rsD!=0 && ((rsD==A3E && TnewE>TuseRsD) || (rsD==A3M && TnewM>TuseRsD)).
- rt hazard: same expression using rtD and TuseRtD.
- md hazard: mdUseD && (md_busy || mdStartE).
- stall = rs hazard | rt hazard | md hazard.
- PC_en = IFID_en = ~stall; IDEX_clr = stall. All three are combinational from the inputs and md_busy.
- Busy counter cnt[CNT_W-1:0]. The FSM state is implied by the counter: IDLE when cnt==0, BUSY when cnt!=0.
  - In IDLE, mdStartE loads cnt with DIV_LAT if mdIsDivE, else MULT_LAT.
  - In BUSY, cnt decrements by 1 each cycle.
  - md_busy = (cnt!=0).
- mdStartE while BUSY is illegal, because the md hazard holds the instr in D. The controller ignores it: no reload, and the decrement continues.
- stall_cycles increments by 1 on every posedge where stall==1 and reset==1. It holds at 32'hFFFFFFFF.
- Register $0 never causes a hazard. A3E/A3M equal to 0 with nonzero Tnew is harmless.

## Timing
- Reset (reset==0 at a posedge):
  - cnt=0, md_busy=0, stall_cycles=0.
  - While reset==0, outputs are forced to PC_en=1, IFID_en=1, IDEX_clr=0, regardless of the hazard inputs.
- Latency of the hazard outputs is 0 cycles: they are purely combinational.
- Mult/div window, with mdStartE=1 at cycle t:
  - md_busy is 1 for cycles t+1 .. t+LAT.
  - An md-class instr held in D stalls cycles t .. t+LAT (LAT+1 cycles).
  - That instr advances at the posedge ending cycle t+LAT.
- Back-to-back: a second mult can issue from E at t+LAT+1 at the earliest.
  - If it does, cnt loads at the posedge ending t+LAT+1.
  - md_busy therefore drops for exactly cycle t+LAT+1.
- Reset mid-operation (cnt!=0): cnt clears at that posedge, and md_busy=0 the next cycle.
- Simultaneous hazards: stall is a single OR of all causes. One stalled cycle counts once in stall_cycles.

## Test plan
- Load-use:
  - Stimulus: lw in E (A3E=8, TnewE=2); D instr with rsD=8, TuseRsD=1.
  - Required: stall=1, so PC_en=0, IFID_en=0, IDEX_clr=1.
  - Then TnewE=1, TuseRsD=1: no stall.
- $0 and no-use cases:
  - Stimulus: rsD=0, A3E=0, TnewE=2, TuseRsD=0.
  - Required: no stall.
  - With TuseRsD=3 and any address match: no stall.
- Mult window:
  - Stimulus: mdStartE=1, mdIsDivE=0 at cycle 0; mdUseD=1 held from cycle 0.
  - Required: stall in cycles 0..5; md_busy=1 in cycles 1..5; IFID_en=1 at cycle 6.
- Div window:
  - Stimulus: mdStartE=1, mdIsDivE=1.
  - Required: md_busy high for exactly 10 cycles.
  - Also: mdStartE pulsed while busy leaves the window length unchanged.
- Reset mid-busy:
  - Stimulus: reset=0 at cycle 3 of a div.
  - Required: md_busy=0, stall_cycles=0, PC_en=1 from the next cycle.
- Stall counter:
  - Stimulus: 7 stalled cycles across two hazard types, including 1 cycle where the rs and md hazards coincide.
  - Required: stall_cycles=7.
  - Preloading near saturation (force) shows the counter holds at FFFFFFFF.
